// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with IF/DX pipeline register, one-entry
// skid buffer for stalls, and a drop state that drains a request outstanding
// at the time of a redirect.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   PC_PIF             next fetch address from pc unit
//   flush, stall       redirect this cycle / DX cannot accept
//   imem_req/addr      instruction memory request and address
//   imem_ack/rdata     memory completion and fetched word
//   PC_IF, instr_IF    IF/DX register address and instruction
//   valid_IF           IF/DX holds a real instruction
//   fetch_misalign     IF/DX instruction is a misaligned-fetch fault
//   pc_hold            PC_PIF not consumed this cycle
//   replay_PC          copy of PC_PIF for the pc unit replay path
module if_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC_PIF,
  input  logic        flush,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_IF,
  output logic [31:0] instr_IF,
  output logic        valid_IF,
  output logic        fetch_misalign,
  output logic        pc_hold,
  output logic [31:0] replay_PC
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_if_q, pc_if_d;
  logic [XLEN-1:0]   instr_if_q, instr_if_d;
  logic              valid_if_q, valid_if_d;
  logic              misalign_q, misalign_d;
  logic [XLEN-1:0]   skid_addr_q, skid_addr_d;
  logic [XLEN-1:0]   skid_data_q, skid_data_d;
  logic              skid_mis_q, skid_mis_d;
  logic [XLEN-1:0]   drop_addr_q, drop_addr_d;

  logic            misaligned;
  logic            accepted;
  logic            reg_free;
  logic [XLEN-1:0] fetch_word;

  // Misaligned fetches never reach memory; they complete immediately as a fault.
  assign misaligned = (PC_PIF[1:0] != 2'b00);
  assign accepted   = (state_q == S_REQ) && (imem_ack || misaligned);
  assign reg_free   = !valid_if_q || !stall;
  assign fetch_word = misaligned ? NOP_INSTR : imem_rdata;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_if_q     <= '0;
      instr_if_q  <= NOP_INSTR;
      valid_if_q  <= 1'b0;
      misalign_q  <= 1'b0;
      skid_addr_q <= '0;
      skid_data_q <= '0;
      skid_mis_q  <= 1'b0;
      drop_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_if_q     <= pc_if_d;
      instr_if_q  <= instr_if_d;
      valid_if_q  <= valid_if_d;
      misalign_q  <= misalign_d;
      skid_addr_q <= skid_addr_d;
      skid_data_q <= skid_data_d;
      skid_mis_q  <= skid_mis_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (flush) state_d = (imem_req && !imem_ack) ? S_DROP : S_REQ;
        else if (accepted && !reg_free) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (flush || !stall) state_d = S_REQ;
      end
      S_DROP: begin
        // The outstanding request completing ends the drain even under a new flush.
        if (imem_ack) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // IF/DX register, skid buffer and drop address updates
  always_comb begin
    pc_if_d     = pc_if_q;
    instr_if_d  = instr_if_q;
    valid_if_d  = valid_if_q;
    misalign_d  = misalign_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;
    skid_mis_d  = skid_mis_q;
    drop_addr_d = drop_addr_q;
    if (flush) begin
      valid_if_d  = 1'b0;
      misalign_d  = 1'b0;
      instr_if_d  = NOP_INSTR;
      skid_addr_d = '0;
      skid_data_d = '0;
      skid_mis_d  = 1'b0;
      if (state_q == S_REQ && imem_req && !imem_ack) drop_addr_d = imem_addr;
    end else if (state_q == S_REQ && accepted) begin
      if (reg_free) begin
        pc_if_d    = PC_PIF;
        instr_if_d = fetch_word;
        valid_if_d = 1'b1;
        misalign_d = misaligned;
      end else begin
        skid_addr_d = PC_PIF;
        skid_data_d = fetch_word;
        skid_mis_d  = misaligned;
      end
    end else if (state_q == S_HOLD) begin
      if (!stall) begin
        pc_if_d    = skid_addr_q;
        instr_if_d = skid_data_q;
        valid_if_d = 1'b1;
        misalign_d = skid_mis_q;
      end
    end else if (reg_free) begin
      // Nothing to deliver: insert a bubble, keep PC_IF.
      valid_if_d = 1'b0;
      instr_if_d = NOP_INSTR;
      misalign_d = 1'b0;
    end
  end

  // Memory request and pc unit handshake outputs
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = PC_PIF;
    pc_hold   = !accepted && !flush;
    case (state_q)
      S_IDLE: pc_hold = 1'b1;
      S_REQ:  imem_req = !misaligned;
      S_HOLD: imem_req = 1'b0;
      S_DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr_q;
      end
      default: imem_req = 1'b0;
    endcase
  end

  assign replay_PC      = PC_PIF;
  assign PC_IF          = pc_if_q;
  assign instr_IF       = instr_if_q;
  assign valid_IF       = valid_if_q;
  assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed-vector bench for if_stage with hand-computed expectations.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst_n;
  logic [31:0] PC_PIF;
  logic        flush;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC_IF;
  logic [31:0] instr_IF;
  logic        valid_IF;
  logic        fetch_misalign;
  logic        pc_hold;
  logic [31:0] replay_PC;

  int n_checks;
  int n_fail;

  if_stage #(.NOP_INSTR(32'h00000013)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PC_PIF        (PC_PIF),
    .flush         (flush),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .PC_IF         (PC_IF),
    .instr_IF      (instr_IF),
    .valid_IF      (valid_IF),
    .fetch_misalign(fetch_misalign),
    .pc_hold       (pc_hold),
    .replay_PC     (replay_PC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive inputs, then let combinational outputs settle before checking them.
  task automatic drive(input logic [31:0] pc, input logic ack, input logic [31:0] rd,
                       input logic st, input logic fl);
    PC_PIF = pc; imem_ack = ack; imem_rdata = rd; stall = st; flush = fl;
    #1;
  endtask

  task automatic check_ifdx(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                            input logic v, input logic m);
    check_eq({tag, ".PC_IF"}, PC_IF, pc);
    check_eq({tag, ".instr_IF"}, instr_IF, ins);
    check_eq({tag, ".valid_IF"}, 32'(valid_IF), 32'(v));
    check_eq({tag, ".misalign"}, 32'(fetch_misalign), 32'(m));
  endtask

  task automatic check_mem(input string tag, input logic rq, input logic [31:0] ad, input logic ph);
    check_eq({tag, ".imem_req"}, 32'(imem_req), 32'(rq));
    if (rq) check_eq({tag, ".imem_addr"}, imem_addr, ad);
    check_eq({tag, ".pc_hold"}, 32'(pc_hold), 32'(ph));
    check_eq({tag, ".replay_PC"}, replay_PC, PC_PIF);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check_ifdx("reset", 32'h0, NOP, 1'b0, 1'b0);
    check_mem("reset", 1'b0, 32'h0, 1'b1);
    rst_n = 1'b1;
    tick(); // IDLE -> REQ

    // Zero-wait fetches of 0, 4, 8
    drive(32'h0, 1'b1, 32'h11110000, 1'b0, 1'b0);
    check_mem("seq0", 1'b1, 32'h0, 1'b0);
    tick();
    check_ifdx("seq0", 32'h0, 32'h11110000, 1'b1, 1'b0);
    drive(32'h4, 1'b1, 32'h11110004, 1'b0, 1'b0);
    check_mem("seq4", 1'b1, 32'h4, 1'b0);
    tick();
    check_ifdx("seq4", 32'h4, 32'h11110004, 1'b1, 1'b0);
    drive(32'h8, 1'b1, 32'h11110008, 1'b0, 1'b0);
    tick();
    check_ifdx("seq8", 32'h8, 32'h11110008, 1'b1, 1'b0);

    // Wait states: ack on the third request cycle for 0x10
    drive(32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
    check_mem("wait1", 1'b1, 32'h10, 1'b1);
    tick();
    check_ifdx("wait1", 32'h8, NOP, 1'b0, 1'b0);
    drive(32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
    check_mem("wait2", 1'b1, 32'h10, 1'b1);
    tick();
    check_ifdx("wait2", 32'h8, NOP, 1'b0, 1'b0);
    drive(32'h10, 1'b1, 32'h22220010, 1'b0, 1'b0);
    check_mem("wait3", 1'b1, 32'h10, 1'b0);
    tick();
    check_ifdx("wait3", 32'h10, 32'h22220010, 1'b1, 1'b0);

    // Stall with an ack: skid buffer then release
    drive(32'h20, 1'b1, 32'h33330020, 1'b0, 1'b0);
    tick();
    check_ifdx("st20", 32'h20, 32'h33330020, 1'b1, 1'b0);
    drive(32'h24, 1'b1, 32'h33330024, 1'b1, 1'b0);
    check_mem("st24", 1'b1, 32'h24, 1'b0);
    tick();
    check_ifdx("hold1", 32'h20, 32'h33330020, 1'b1, 1'b0);
    drive(32'h28, 1'b0, 32'h0, 1'b1, 1'b0);
    check_mem("hold1", 1'b0, 32'h0, 1'b1);
    tick();
    check_ifdx("hold2", 32'h20, 32'h33330020, 1'b1, 1'b0);
    drive(32'h28, 1'b0, 32'h0, 1'b0, 1'b0);
    check_mem("hold2", 1'b0, 32'h0, 1'b1);
    tick();
    check_ifdx("unstall", 32'h24, 32'h33330024, 1'b1, 1'b0);

    // Flush while 0x30 outstanding, redirect to 0x100
    drive(32'h30, 1'b0, 32'h0, 1'b0, 1'b1);
    check_mem("flush", 1'b1, 32'h30, 1'b0);
    tick();
    check_ifdx("drop1", 32'h24, NOP, 1'b0, 1'b0);
    drive(32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    check_mem("drop1", 1'b1, 32'h30, 1'b1);
    tick();
    drive(32'h100, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    check_mem("drop2", 1'b1, 32'h30, 1'b1);
    tick();
    check_ifdx("dropdone", 32'h24, NOP, 1'b0, 1'b0);
    drive(32'h100, 1'b1, 32'h44440100, 1'b0, 1'b0);
    check_mem("redir", 1'b1, 32'h100, 1'b0);
    tick();
    check_ifdx("redir", 32'h100, 32'h44440100, 1'b1, 1'b0);

    // Misaligned fetch: no memory request, fault with NOP
    drive(32'h42, 1'b0, 32'h55555555, 1'b0, 1'b0);
    check_mem("mis", 1'b0, 32'h0, 1'b0);
    tick();
    check_ifdx("mis", 32'h42, NOP, 1'b1, 1'b1);

    // Flush in HOLD discards the skid entry
    drive(32'h50, 1'b1, 32'h66660050, 1'b1, 1'b0);
    tick();
    check_ifdx("hold50", 32'h42, NOP, 1'b1, 1'b1);
    drive(32'h54, 1'b0, 32'h0, 1'b1, 1'b1);
    check_mem("hflush", 1'b0, 32'h0, 1'b0);
    tick();
    check_ifdx("hflush", 32'h42, NOP, 1'b0, 1'b0);
    drive(32'h60, 1'b1, 32'h77770060, 1'b0, 1'b0);
    check_mem("after_hflush", 1'b1, 32'h60, 1'b0);
    tick();
    check_ifdx("f60", 32'h60, 32'h77770060, 1'b1, 1'b0);

    // Asynchronous reset while in HOLD
    drive(32'h64, 1'b1, 32'h77770064, 1'b1, 1'b0);
    tick();
    drive(32'h68, 1'b0, 32'h0, 1'b1, 1'b0);
    check_mem("prerst", 1'b0, 32'h0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_ifdx("arst", 32'h0, NOP, 1'b0, 1'b0);
    check_mem("arst", 1'b0, 32'h0, 1'b1);
    tick();
    check_ifdx("arst_hold", 32'h0, NOP, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
